alu_acc: RTL and testbench
==========================

ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update only on the rising edge of acc_clk.
REQ-002 acc_clk  in  1  system clock.
REQ-003 acc_rst  in  1  synchronous reset, active-high.
REQ-004 acc_bus_in  in  8  data bus value, operand source for A and B.
REQ-005 acc_ld_a  in  1  load A from acc_bus_in when idle.
REQ-006 acc_start  in  1  start one ALU operation; B taken from acc_bus_in.
REQ-007 acc_op  in  1  operation select: 0 add, 1 subtract; sampled with acc_start.
REQ-008 alu_bus  in  8  ALU result, valid while alu_out=1.
REQ-009 alu_cy  in  1  ALU carry/borrow, valid while alu_out=1.
REQ-010 alu_a  out  8  register A to ALU.
REQ-011 alu_b  out  8  register B to ALU.
REQ-012 alu_out  out  1  ALU result-drive enable.
REQ-013 alu_cut  out  1  ALU subtract select.
REQ-014 acc_busy  out  1  operation in progress.
REQ-015 acc_done  out  1  one-cycle completion strobe.
REQ-016 acc_cf  out  1  carry flag from last completed operation.
REQ-017 acc_zf  out  1  zero flag from last completed operation.

Function
REQ-018 FSM SHALL have exactly three states: IDLE, EXEC, WB; outputs alu_out, alu_cut, acc_busy, acc_done SHALL be Moore outputs of state and latched op.
REQ-019 IDLE: acc_start=1 -> B<=acc_bus_in, op latched, next EXEC; else acc_ld_a=1 -> A<=acc_bus_in, stay IDLE.
REQ-020 acc_start and acc_ld_a both high in IDLE: start wins; A SHALL NOT change that cycle.
REQ-021 EXEC: alu_out=1, alu_cut=latched op, acc_busy=1; next WB unconditionally.
REQ-022 WB: alu_out=1, alu_cut=latched op, acc_busy=1, acc_done=1; at end of cycle A<=alu_bus, acc_cf<=alu_cy, acc_zf<=(alu_bus==8'd0); next IDLE.
REQ-023 Latency: start sampled at edge N; EXEC during cycle N+1; WB/acc_done during N+2; new A, acc_cf, acc_zf visible from cycle N+3.
REQ-024 In IDLE alu_out=0, alu_cut=0, acc_busy=0, acc_done=0.
REQ-025 acc_start and acc_ld_a SHALL be ignored in EXEC and WB; A and B SHALL hold.
REQ-026 alu_a and alu_b SHALL be constant through EXEC and WB of an operation.
REQ-027 Back-to-back: acc_start high in the IDLE cycle after WB SHALL start next operation using the updated A.
REQ-028 acc_cf and acc_zf SHALL change only at end of WB or on reset.
REQ-029 Result width 8 bits; overflow wraps modulo 256; carry/borrow reported solely via alu_cy as supplied.

Reset
REQ-030 acc_rst=1 at a rising edge SHALL force IDLE, A=B=0, op=0, acc_cf=0, acc_zf=0, overriding all other inputs.
REQ-031 Reset in EXEC or WB SHALL abort the operation: no write to A or flags, no acc_done from that operation.
REQ-032 After reset release the first active edge SHALL accept acc_ld_a or acc_start.

Verification (bench pairs block with the team's ALU)
REQ-033 Load A=10, start add with bus=10 -> acc_done in cycle N+2; A=20, acc_cf=0, acc_zf=0; alu_out high exactly 2 cycles.
REQ-034 Load A=200, start add with bus=100 -> A=44, acc_cf=1, acc_zf=0.
REQ-035 Load A=10, start subtract with bus=10 -> alu_cut=1 during EXEC/WB; A=0, acc_zf=1.
REQ-036 acc_start and acc_ld_a together with bus=7, A=5, op add -> A=12; acc_start pulsed during EXEC/WB ignored, one acc_done only.
REQ-037 acc_rst asserted in WB of 10+10 -> A=0, flags 0, no acc_done, IDLE next cycle.
REQ-038 Two back-to-back adds of 1 from A=254 -> A=255 (cf=0), then A=0 (cf=1, zf=1).

Source files
------------

// File: rtl/alu_acc.sv
// alu_acc: accumulator/sequencer that feeds an external 8-bit ALU and writes its result back into A
//   acc_clk, acc_rst            clock, synchronous active-high reset
//   acc_bus_in, acc_ld_a        operand bus, load A when idle
//   acc_start, acc_op           start one operation (B from bus), op 0 add / 1 subtract
//   alu_bus, alu_cy             ALU result and carry/borrow, valid while alu_out=1
//   alu_a, alu_b                registers A and B to the ALU
//   alu_out, alu_cut            ALU result-drive enable, subtract select
//   acc_busy, acc_done          operation in progress, one-cycle completion strobe
//   acc_cf, acc_zf              carry and zero flags of the last completed operation
module alu_acc (
  input  logic       acc_clk,
  input  logic       acc_rst,
  input  logic [7:0] acc_bus_in,
  input  logic       acc_ld_a,
  input  logic       acc_start,
  input  logic       acc_op,
  input  logic [7:0] alu_bus,
  input  logic       alu_cy,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_out,
  output logic       alu_cut,
  output logic       acc_busy,
  output logic       acc_done,
  output logic       acc_cf,
  output logic       acc_zf
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  logic [1:0] state;
  logic       op;
  always_comb begin
    alu_out  = state == EXEC || state == WB;
    alu_cut  = alu_out & op;
    acc_busy = alu_out;
    acc_done = state == WB;
  end
  always_ff @(posedge acc_clk) begin
    if (acc_rst) begin
      state  <= IDLE;
      alu_a  <= 8'd0;
      alu_b  <= 8'd0;
      op     <= 1'b0;
      acc_cf <= 1'b0;
      acc_zf <= 1'b0;
    end else if (state == IDLE) begin
      if (acc_start) begin
        alu_b <= acc_bus_in;
        op    <= acc_op;
        state <= EXEC;
      end else if (acc_ld_a) alu_a <= acc_bus_in;
    end else if (state == EXEC) state <= WB;
    else begin
      // the unused encoding falls back to IDLE without touching A or the flags
      if (state == WB) begin
        alu_a  <= alu_bus;
        acc_cf <= alu_cy;
        acc_zf <= ~|alu_bus;
      end
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc: directed self-checking bench for alu_acc paired with a behavioural 8-bit add/sub ALU
module tb_alu_acc;
  logic       clk = 1'b0;
  logic       rst, ld_a, start, op;
  logic [7:0] bus;
  logic [7:0] alu_bus, alu_a, alu_b;
  logic       alu_cy, alu_out, alu_cut, busy, done, cf, zf;
  logic [8:0] s;
  int         checks = 0, failures = 0;
  logic [7:0] a_exp = 8'd0;
  logic       cf_exp = 1'b0, zf_exp = 1'b0;
  always #5 clk = ~clk;
  alu_acc dut (
    .acc_clk(clk), .acc_rst(rst), .acc_bus_in(bus), .acc_ld_a(ld_a),
    .acc_start(start), .acc_op(op), .alu_bus(alu_bus), .alu_cy(alu_cy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_cut(alu_cut),
    .acc_busy(busy), .acc_done(done), .acc_cf(cf), .acc_zf(zf)
  );
  assign s = alu_cut ? {1'b0, alu_a} - {1'b0, alu_b} : {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_bus = alu_out ? s[7:0] : 8'h00;
  assign alu_cy = alu_out & s[8];
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, " alu_out"}, 8'(alu_out), 8'd0);
    chk({tag, " alu_cut"}, 8'(alu_cut), 8'd0);
    chk({tag, " busy"}, 8'(busy), 8'd0);
    chk({tag, " done"}, 8'(done), 8'd0);
    chk({tag, " a"}, alu_a, a_exp);
    chk({tag, " cf"}, 8'(cf), 8'(cf_exp));
    chk({tag, " zf"}, 8'(zf), 8'(zf_exp));
  endtask
  task automatic load(input logic [7:0] v);
    ld_a = 1'b1;
    bus = v;
    @(negedge clk);
    ld_a = 1'b0;
    a_exp = v;
    chk("load a", alu_a, v);
  endtask
  task automatic run(input string tag, input logic o, input logic [7:0] bv, input logic ld, input logic noise,
                     input logic [7:0] r, input logic c, input logic z);
    start = 1'b1;
    op = o;
    bus = bv;
    ld_a = ld;
    @(negedge clk);
    start = 1'b0;
    ld_a = 1'b0;
    chk({tag, " exec alu_out"}, 8'(alu_out), 8'd1);
    chk({tag, " exec busy"}, 8'(busy), 8'd1);
    chk({tag, " exec done"}, 8'(done), 8'd0);
    chk({tag, " exec cut"}, 8'(alu_cut), 8'(o));
    chk({tag, " exec a"}, alu_a, a_exp);
    chk({tag, " exec b"}, alu_b, bv);
    chk({tag, " exec cf"}, 8'(cf), 8'(cf_exp));
    chk({tag, " exec zf"}, 8'(zf), 8'(zf_exp));
    if (noise) begin
      start = 1'b1;
      ld_a = 1'b1;
      bus = 8'h99;
    end
    @(negedge clk);
    chk({tag, " wb alu_out"}, 8'(alu_out), 8'd1);
    chk({tag, " wb busy"}, 8'(busy), 8'd1);
    chk({tag, " wb done"}, 8'(done), 8'd1);
    chk({tag, " wb cut"}, 8'(alu_cut), 8'(o));
    chk({tag, " wb a"}, alu_a, a_exp);
    chk({tag, " wb b"}, alu_b, bv);
    chk({tag, " wb cf"}, 8'(cf), 8'(cf_exp));
    @(negedge clk);
    start = 1'b0;
    ld_a = 1'b0;
    a_exp = r;
    cf_exp = c;
    zf_exp = z;
    idle_chk({tag, " result"});
  endtask
  initial begin
    rst = 1'b1;
    ld_a = 1'b1;
    start = 1'b1;
    op = 1'b1;
    bus = 8'hff;
    repeat (2) @(negedge clk);
    chk("reset b", alu_b, 8'd0);
    idle_chk("reset");
    rst = 1'b0;
    ld_a = 1'b0;
    start = 1'b0;
    op = 1'b0;
    load(8'd10);
    run("add10+10", 1'b0, 8'd10, 1'b0, 1'b0, 8'd20, 1'b0, 1'b0);
    load(8'd200);
    run("add200+100", 1'b0, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1, 1'b0);
    load(8'd10);
    run("sub10-10", 1'b1, 8'd10, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    load(8'd5);
    run("start+ld", 1'b0, 8'd7, 1'b1, 1'b1, 8'd12, 1'b0, 1'b0);
    @(negedge clk);
    idle_chk("after noise");
    load(8'd254);
    run("b2b first", 1'b0, 8'd1, 1'b0, 1'b0, 8'd255, 1'b0, 1'b0);
    run("b2b second", 1'b0, 8'd1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    load(8'd10);
    start = 1'b1;
    bus = 8'd10;
    @(negedge clk);
    start = 1'b0;
    chk("abort exec busy", 8'(busy), 8'd1);
    @(negedge clk);
    chk("abort wb done", 8'(done), 8'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_exp = 8'd0;
    cf_exp = 1'b0;
    zf_exp = 1'b0;
    idle_chk("abort");
    chk("abort b", alu_b, 8'd0);
    load(8'h33);
    chk("post abort done", 8'(done), 8'd0);
    run("post reset add", 1'b0, 8'h11, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
